// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the clock-domain reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    // Width of the single shared state counter: enough to reach the largest
    // terminal count of any state. Never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchroniser for a vector of independent asynchronous bits.
// Each bit is synchronised on its own; no coherency between bits is implied.
module sync_bits #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 captures the raw input; stage STAGES-1 is the synchronised output.
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift every stage one position towards the output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops, cleared by the async reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Per-clock reset sequencer: resets the PLL, waits for lock, holds the domain
// reset for a settle time, then releases a sync-deasserted active-low reset.
// Lock loss in RUN restarts the sequence; repeated lock timeouts end in FAULT.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PLL_RST   | pll_rst high for PLL_RST_CYCLES cycles
//   WAIT_LOCK | pll_rst low, waiting for all locks, timeout -> retry/FAULT
//   HOLD      | all locks high, counting HOLD_CYCLES before release
//   RUN       | domain reset released, filtering lock loss
//   FAULT     | retries exhausted, terminal until n_rst
module pll_reset_seq
    import rst_seq_pkg::*;
#(
    parameter int N_LOCK         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int HOLD_CYCLES    = 1024,
    parameter int LOSS_FILTER    = 4,
    parameter int MAX_RETRIES    = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [N_LOCK-1:0] lock,
    output logic              pll_rst,
    output logic              n_rst_out,
    output logic              ready,
    output logic              fault,
    output logic [RW-1:0]     retry_cnt,
    output logic [2:0]        state_dbg
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES, LOSS_FILTER);

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_FILTER - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic [N_LOCK-1:0] lock_sync;
    logic              all_lock;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          n_rst_out_q, n_rst_out_d;

    sync_bits #(
        .WIDTH  (N_LOCK),
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (lock),
        .q     (lock_sync)
    );

    assign all_lock = &lock_sync;

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (all_lock) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_PLL_RST;
                    end
                end
            end
            ST_HOLD: begin
                if (!all_lock)               state_d = ST_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                // cnt tracks the current run of consecutive low-lock cycles
                if (all_lock)                cnt_d   = '0;
                else if (cnt_q == LOSS_LAST) state_d = ST_PLL_RST;
            end
            ST_FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

        // Registered from next state so the release edge is the RUN entry edge.
        n_rst_out_d = (state_d == ST_RUN);
    end

    // State, counter, retry and domain-reset registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            n_rst_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            n_rst_out_q <= n_rst_out_d;
        end
    end

    assign pll_rst   = (state_q == ST_PLL_RST) || (state_q == ST_FAULT);
    assign ready     = (state_q == ST_RUN);
    assign fault     = (state_q == ST_FAULT);
    assign n_rst_out = n_rst_out_q;
    assign retry_cnt = retry_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with the small test configuration.
module tb_pll_reset_seq;

    localparam logic [2:0] S_PR = 3'd0;
    localparam logic [2:0] S_WL = 3'd1;
    localparam logic [2:0] S_HO = 3'd2;
    localparam logic [2:0] S_RU = 3'd3;
    localparam logic [2:0] S_FA = 3'd4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] lock = 2'b00;
    logic       pll_rst, n_rst_out, ready, fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    pll_reset_seq #(
        .N_LOCK         (2),
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .HOLD_CYCLES    (8),
        .LOSS_FILTER    (3),
        .MAX_RETRIES    (2)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .lock      (lock),
        .pll_rst   (pll_rst),
        .n_rst_out (n_rst_out),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pll_rst;
        logic       n_rst_out;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        logic [1:0] lock;
        obs_t       exp;
    } vec_t;

    obs_t sb_q[$];
    vec_t tbl[25];
    int   checks = 0;
    int   errors = 0;

    // Expected outputs for a given state and retry count.
    function automatic obs_t mk(input logic [2:0] st, input logic [1:0] r);
        obs_t o;
        o.pll_rst   = (st == S_PR) || (st == S_FA);
        o.n_rst_out = (st == S_RU);
        o.ready     = (st == S_RU);
        o.fault     = (st == S_FA);
        o.retry     = r;
        o.st        = st;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pll_rst   = pll_rst;
        o.n_rst_out = n_rst_out;
        o.ready     = ready;
        o.fault     = fault;
        o.retry     = retry_cnt;
        o.st        = state_dbg;
        return o;
    endfunction

    task automatic chk_obs(input string name);
        obs_t e, a;
        e = sb_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got {pll_rst,n_rst_out,ready,fault,retry,st}=%b want %b",
                     name, a, e);
        end
    endtask

    task automatic expect_now(input obs_t e, input string name);
        sb_q.push_back(e);
        chk_obs(name);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Drive lock, cross one active edge, compare at the following falling edge.
    task automatic cyc(input logic [1:0] l, input obs_t e, input string name);
        lock = l;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk_obs(name);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int n);
        n = 0;
        while (state_dbg !== st && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (state_dbg !== st) begin
            checks++;
            errors++;
            $display("FAIL wait_state timeout got st=%0d want %0d", state_dbg, st);
        end
    endtask

    task automatic wait_leave(input int budget, output int n);
        logic [2:0] s0;
        s0 = state_dbg;
        n  = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (state_dbg === s0 && n < budget);
        if (state_dbg === s0) begin
            checks++;
            errors++;
            $display("FAIL wait_leave timeout still st=%0d", s0);
        end
    endtask

    initial begin
        int n;

        // Nominal bring-up: entry i covers active edge i+1 after release.
        // lock is raised for edge 10; PLL_RST covers edges 1-3, WAIT_LOCK
        // 4-11 (two sync edges plus the decision edge), HOLD 12-19, RUN from 20.
        for (int i = 0; i < 25; i++) begin
            int e;
            logic [2:0] st;
            e = i + 1;
            if (e <= 3)       st = S_PR;
            else if (e <= 11) st = S_WL;
            else if (e <= 19) st = S_HO;
            else              st = S_RU;
            tbl[i].lock = (e >= 10) ? 2'b11 : 2'b00;
            tbl[i].exp  = mk(st, 2'd0);
        end

        // Reset values
        repeat (3) @(negedge clk);
        expect_now(mk(S_PR, 2'd0), "reset_values");

        n_rst = 1'b1;
        for (int i = 0; i < 25; i++) cyc(tbl[i].lock, tbl[i].exp, $sformatf("nominal_e%0d", i + 1));

        // RUN glitch of 2 cycles is filtered
        cyc(2'b00, mk(S_RU, 2'd0), "glitch2_a");
        cyc(2'b00, mk(S_RU, 2'd0), "glitch2_b");
        for (int i = 0; i < 4; i++) cyc(2'b11, mk(S_RU, 2'd0), "glitch2_hold");

        // 3-cycle loss: leave RUN on the fourth edge after the drop
        cyc(2'b00, mk(S_RU, 2'd0), "loss3_a");
        cyc(2'b00, mk(S_RU, 2'd0), "loss3_b");
        cyc(2'b00, mk(S_RU, 2'd0), "loss3_c");
        cyc(2'b11, mk(S_RU, 2'd0), "loss3_d");
        cyc(2'b11, mk(S_PR, 2'd0), "loss3_exit");
        wait_state(S_RU, 60, n);
        chk_int("relock_after_loss_cycles", n, 4 + 1 + 8);

        // Async reset in RUN drops n_rst_out without a clock edge
        n_rst = 1'b0;
        #1;
        expect_now(mk(S_PR, 2'd0), "async_rst_in_run");
        @(negedge clk);
        n_rst = 1'b1;
        wait_state(S_HO, 30, n);
        chk_int("hold_entry_after_release", n, 5);
        for (int i = 0; i < 3; i++) cyc(2'b11, mk(S_HO, 2'd0), "pre_async_hold");

        // Async reset mid-HOLD raises pll_rst immediately
        n_rst = 1'b0;
        #1;
        expect_now(mk(S_PR, 2'd0), "async_rst_in_hold");
        @(negedge clk);
        n_rst = 1'b1;
        cyc(2'b11, mk(S_PR, 2'd0), "after_release_state0");

        // Lock drop at HOLD cnt=5 returns to WAIT_LOCK
        wait_state(S_HO, 30, n);
        chk_int("hold_entry_drop_test", n, 4);
        for (int i = 0; i < 3; i++) cyc(2'b11, mk(S_HO, 2'd0), "drop_hold");
        cyc(2'b00, mk(S_HO, 2'd0), "drop_a");
        cyc(2'b00, mk(S_HO, 2'd0), "drop_b");
        cyc(2'b00, mk(S_WL, 2'd0), "drop_to_wait");
        lock = 2'b11;
        wait_state(S_HO, 40, n);
        chk_int("relock_to_hold", n, 3);
        wait_state(S_RU, 40, n);
        chk_int("full_hold_after_drop", n, 8);
        expect_now(mk(S_RU, 2'd0), "run_after_drop");

        // Partial lock: three timeouts end in FAULT
        lock  = 2'b01;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        wait_state(S_WL, 20, n);
        chk_int("partial_first_wait", n, 4);
        for (int k = 0; k < 3; k++) begin
            wait_leave(60, n);
            chk_int($sformatf("timeout_%0d_cycles", k), n, 32);
            if (k < 2) begin
                expect_now(mk(S_PR, 2'(k + 1)), $sformatf("retry_%0d", k + 1));
                wait_state(S_WL, 20, n);
                chk_int($sformatf("retry_%0d_pll_rst_len", k + 1), n, 4);
            end else begin
                expect_now(mk(S_FA, 2'd2), "fault_entry");
            end
        end
        for (int i = 0; i < 5; i++) cyc(2'b01, mk(S_FA, 2'd2), "fault_sticky");
        for (int i = 0; i < 12; i++) cyc(2'b11, mk(S_FA, 2'd2), "fault_sticky_locked");
        n_rst = 1'b0;
        #1;
        expect_now(mk(S_PR, 2'd0), "fault_cleared_by_rst");

        // Retry then success: retry_cnt cleared on RUN entry
        lock = 2'b00;
        @(negedge clk);
        n_rst = 1'b1;
        wait_state(S_WL, 20, n);
        chk_int("retry_succ_wait", n, 4);
        wait_leave(60, n);
        chk_int("retry_succ_timeout", n, 32);
        expect_now(mk(S_PR, 2'd1), "retry_succ_retry1");
        lock = 2'b11;
        wait_state(S_HO, 30, n);
        chk_int("retry_succ_hold_entry", n, 5);
        expect_now(mk(S_HO, 2'd1), "retry_succ_hold_retry");
        wait_state(S_RU, 30, n);
        chk_int("retry_succ_hold_len", n, 8);
        expect_now(mk(S_RU, 2'd0), "retry_succ_run_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
